// File: rtl/risc_datapath_pkg.sv
// Shared types for the RISC datapath and its controller: opcodes, the
// 8-cycle instruction phase sequence and the default word widths.
package risc_datapath_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 5;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ,
    ADD,
    AND,
    XOR,
    LDA,
    STO,
    JMP
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR = 3'd0,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } phase_t;

endpackage

// File: rtl/risc_datapath_if.sv
// Controller/memory <-> datapath bundle. The master drives strobes and read
// data; the slave (datapath) returns status, opcode and memory controls.
interface risc_datapath_if
  import risc_datapath_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) ();

  logic              mem_rd;
  logic              load_ir;
  logic              halt;
  logic              inc_pc;
  logic              load_ac;
  logic              load_pc;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_rdata;
  opcode_t           opcode;
  logic              zero;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic              halted;
  logic              proto_err;

  modport master (
    output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, mem_rdata,
    input  opcode, zero, mem_addr, mem_wdata, mem_re, mem_we, halted, proto_err
  );

  modport slave (
    input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, mem_rdata,
    output opcode, zero, mem_addr, mem_wdata, mem_re, mem_we, halted, proto_err
  );

endinterface

// File: rtl/risc_alu.sv
// Combinational accumulator ALU; opcodes that do not write AC pass AC through.
module risc_alu
  import risc_datapath_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  opcode_t           i_opcode,
  input  logic [DWIDTH-1:0] i_ac,
  input  logic [DWIDTH-1:0] i_data,
  output logic [DWIDTH-1:0] o_result
);

  always_comb begin
    o_result = i_ac;
    case (i_opcode)
      ADD:     o_result = i_ac + i_data;
      AND:     o_result = i_ac & i_data;
      XOR:     o_result = i_ac ^ i_data;
      LDA:     o_result = i_data;
      default: o_result = i_ac;
    endcase
  end

endmodule

// File: rtl/risc_datapath.sv
// RISC datapath: PC, IR, AC, ALU and address mux driven by controller strobes.
// Optional strobe/phase protocol checker enabled by DATAPATH_PROTO_CHECK_EN.
module risc_datapath
  import risc_datapath_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic            clk,
  input logic            rst_,
  risc_datapath_if.slave bus
);

  logic [AWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_ir;
  logic [DWIDTH-1:0] r_ac;
  phase_t            r_phase;
  logic              r_halted;

  logic [DWIDTH-1:0] w_alu;
  logic [AWIDTH-1:0] w_operand;
  opcode_t           w_opcode;

  assign w_operand = r_ir[AWIDTH-1:0];
  assign w_opcode  = opcode_t'(r_ir[DWIDTH-1:DWIDTH-3]);

  risc_alu #(.DWIDTH(DWIDTH)) u_alu (
    .i_opcode (w_opcode),
    .i_ac     (r_ac),
    .i_data   (bus.mem_rdata),
    .o_result (w_alu)
  );

  // Strobes seen on the cycle halt is first sampled still land; after that, freeze.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_ac     <= '0;
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_phase <= phase_t'(r_phase + 3'd1);
      if (bus.load_ir) r_ir <= bus.mem_rdata;
      if (bus.load_pc)     r_pc <= w_operand;
      else if (bus.inc_pc) r_pc <= r_pc + 1'b1;
      if (bus.load_ac) r_ac <= w_alu;
      if (bus.halt)    r_halted <= 1'b1;
    end
  end

  assign bus.opcode    = w_opcode;
  assign bus.zero      = (r_ac == '0);
  assign bus.mem_addr  = (r_phase >= OP_ADDR) ? w_operand : r_pc;
  assign bus.mem_wdata = r_ac;
  assign bus.mem_re    = bus.mem_rd & ~r_halted;
  assign bus.mem_we    = bus.mem_wr & ~r_halted;
  assign bus.halted    = r_halted;

`ifdef DATAPATH_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_violation;

  always_comb begin
    w_violation = (bus.load_ir && !(r_phase inside {INST_LOAD, IDLE})) ||
                  (bus.mem_wr  && !(r_phase inside {ALU_OP, STORE}))   ||
                  (bus.load_ac && (r_phase != STORE))                  ||
                  (bus.mem_wr  && bus.mem_rd);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                         r_proto_err <= 1'b0;
    else if (!r_halted && w_violation) r_proto_err <= 1'b1;
  end

  assign bus.proto_err = r_proto_err;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_risc_datapath.sv
// Directed self-checking bench for risc_datapath: walks instructions phase by
// phase, then exercises PC priority, halt freeze, reset and the proto checker.
module tb_risc_datapath;
  import risc_datapath_pkg::*;

`ifdef DATAPATH_PROTO_CHECK_EN
  localparam logic EXP_PROTO = 1'b1;
`else
  localparam logic EXP_PROTO = 1'b0;
`endif

  logic clk;
  logic rst_;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ph     = 0;
  bit   hmodel = 1'b0;

  risc_datapath_if #(.DWIDTH(8), .AWIDTH(5)) bus ();

  risc_datapath #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.mem_rd  = 1'b0;
    bus.load_ir = 1'b0;
    bus.halt    = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_ac = 1'b0;
    bus.load_pc = 1'b0;
    bus.mem_wr  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!hmodel) ph = (ph + 1) % 8;
    if (bus.halt) hmodel = 1'b1;
    clr();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 8 && ph != target; i++) tick();
  endtask

  task automatic do_instr(input logic [7:0] ir_word, input logic [7:0] data);
    run_to(2);
    bus.load_ir = 1'b1; bus.mem_rdata = ir_word;
    tick();
    run_to(7);
    bus.load_ac = 1'b1; bus.mem_rdata = data;
    tick();
  endtask

  initial begin
    rst_ = 1'b0;
    clr();
    bus.mem_rdata = '0;
    #3;
    check("rst_addr",   bus.mem_addr,  0);
    check("rst_opcode", bus.opcode,    HLT);
    check("rst_zero",   bus.zero,      1);
    check("rst_halted", bus.halted,    0);
    check("rst_re",     bus.mem_re,    0);
    check("rst_we",     bus.mem_we,    0);
    check("rst_ac",     bus.mem_wdata, 0);
    check("rst_proto",  bus.proto_err, 0);
    #9 rst_ = 1'b1;

    // LDA 5 with zero data; PC bumped once in phase 3
    check("ph0_addr", bus.mem_addr, 0);
    bus.mem_rd = 1'b1; #1;
    check("ph0_re", bus.mem_re, 1);
    tick();
    check("ph1_addr", bus.mem_addr, 0);
    tick();
    check("ph2_addr", bus.mem_addr, 0);
    bus.load_ir = 1'b1; bus.mem_rdata = 8'hA5;
    tick();
    check("ph3_opcode", bus.opcode, LDA);
    check("ph3_addr",   bus.mem_addr, 0);
    bus.inc_pc = 1'b1;
    tick();
    check("ph4_addr",   bus.mem_addr, 5);
    check("ph4_opcode", bus.opcode, LDA);
    run_to(7);
    bus.load_ac = 1'b1; bus.mem_rdata = 8'h00;
    tick();
    check("lda0_ac",   bus.mem_wdata, 8'h00);
    check("lda0_zero", bus.zero, 1);
    check("pc1_addr",  bus.mem_addr, 1);

    do_instr(8'hA3, 8'hF0);
    check("ldaF0_ac",   bus.mem_wdata, 8'hF0);
    check("ldaF0_zero", bus.zero, 0);
    do_instr(8'h44, 8'h20);
    check("add_opcode", bus.opcode, ADD);
    check("add_ac",     bus.mem_wdata, 8'h10);
    check("add_zero",   bus.zero, 0);
    do_instr(8'h80, 8'h10);
    check("xor_ac",   bus.mem_wdata, 8'h00);
    check("xor_zero", bus.zero, 1);
    do_instr(8'hA0, 8'h3C);
    do_instr(8'h60, 8'h0F);
    check("and_ac", bus.mem_wdata, 8'h0C);

    // STO: write strobe passes through, AC unaffected by load_ac
    run_to(2);
    bus.load_ir = 1'b1; bus.mem_rdata = 8'hC2;
    tick();
    run_to(6);
    bus.mem_wr = 1'b1; #1;
    check("sto_we", bus.mem_we, 1);
    tick();
    bus.load_ac = 1'b1; bus.mem_rdata = 8'hFF;
    tick();
    check("sto_ac_hold", bus.mem_wdata, 8'h0C);

    // JMP 31, then inc wraps to 0, then load_pc beats inc_pc
    run_to(2);
    bus.load_ir = 1'b1; bus.mem_rdata = 8'hFF;
    tick();
    run_to(6);
    bus.load_pc = 1'b1;
    tick();
    run_to(0);
    check("jmp31_addr", bus.mem_addr, 31);
    run_to(1);
    bus.inc_pc = 1'b1;
    tick();
    check("pc_wrap", bus.mem_addr, 0);
    bus.load_ir = 1'b1; bus.mem_rdata = 8'hE9;
    tick();
    run_to(6);
    bus.load_pc = 1'b1; bus.inc_pc = 1'b1;
    tick();
    run_to(0);
    check("pc_prio", bus.mem_addr, 9);

    // Halt with concurrent inc_pc/mem_wr; then everything freezes
    run_to(1);
    bus.halt = 1'b1; bus.inc_pc = 1'b1; bus.mem_wr = 1'b1; #1;
    check("halt_cycle_we", bus.mem_we, 1);
    tick();
    check("halted_set", bus.halted, 1);
    check("halt_pc_inc", bus.mem_addr, 10);
    for (int i = 0; i < 3; i++) begin
      bus.mem_wr = 1'b1; bus.mem_rd = 1'b1; bus.inc_pc = 1'b1;
      bus.load_ac = 1'b1; bus.load_ir = 1'b1; bus.mem_rdata = 8'h41;
      #1;
      check("halt_we", bus.mem_we, 0);
      check("halt_re", bus.mem_re, 0);
      tick();
    end
    check("halt_addr_hold", bus.mem_addr, 10);
    check("halt_ac_hold",   bus.mem_wdata, 8'h0C);
    check("halt_ir_hold",   bus.opcode, JMP);
    check("halt_sticky",    bus.halted, 1);

    #2 rst_ = 1'b0;
    #1;
    check("rst2_halted", bus.halted, 0);
    check("rst2_addr",   bus.mem_addr, 0);
    check("rst2_ac",     bus.mem_wdata, 0);
    check("rst2_opcode", bus.opcode, HLT);
    check("rst2_zero",   bus.zero, 1);
    #2 rst_ = 1'b1;
    hmodel = 1'b0;
    ph = 0;

    // load_ir in phase 5 is a protocol violation
    check("proto_clean", bus.proto_err, 0);
    run_to(5);
    bus.load_ir = 1'b1; bus.mem_rdata = 8'h00;
    tick();
    check("proto_set", bus.proto_err, EXP_PROTO);
    tick();
    tick();
    check("proto_sticky", bus.proto_err, EXP_PROTO);
    #2 rst_ = 1'b0;
    #1;
    check("proto_rst", bus.proto_err, 0);
    #2 rst_ = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
Name: risc_datapath

Overview:
- Responder side of the controller interface: consumes the seven control strobes (mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr).
- Returns opcode and zero to the controller.
- Holds the program counter, instruction register, accumulator, ALU and memory-address mux.
- Sits between the control FSM and a synchronous-read program/data memory.
- Instruction word: opcode in [DWIDTH-1:DWIDTH-3], operand address in [AWIDTH-1:0].

Parameters:
- DWIDTH, 8, data/instruction word width (at least AWIDTH+3).
- AWIDTH, 5, memory address width.

Ports:
- clk  input  1  clock, rising-edge.
- rst_  input  1  reset, asynchronous, active-low.
- mem_rd  input  1  controller read strobe.
- load_ir  input  1  capture mem_rdata into IR.
- halt  input  1  controller halt strobe.
- inc_pc  input  1  increment PC.
- load_ac  input  1  write ALU result into AC.
- load_pc  input  1  load PC from IR operand.
- mem_wr  input  1  controller write strobe.
- mem_rdata  input  DWIDTH  memory read data.
- opcode  output  opcode_t  IR opcode field.
- zero  output  1  AC equals zero.
- mem_addr  output  AWIDTH  memory address.
- mem_wdata  output  DWIDTH  write data, always equal to AC.
- mem_re  output  1  mem_rd gated by not-halted.
- mem_we  output  1  mem_wr gated by not-halted.
- halted  output  1  sticky halt status.
- proto_err  output  1  protocol violation flag (see Optional Feature).

Behaviour:
- Reset (rst_ low, asynchronous): PC=0, IR=0 (opcode=HLT), AC=0 (zero=1), phase=0, halted=0, proto_err=0, mem_re=0, mem_we=0, mem_addr=0.
- Phase counter (3 bit): increments by 1 every clock while halted=0 and wraps 7->0. This mirrors the controller's fixed 8-cycle instruction sequence; phase 0 is the first cycle after reset release.
- mem_addr is combinational:
  - phases 0-3 (fetch): mem_addr = PC.
  - phases 4-7 (execute): mem_addr = IR[AWIDTH-1:0].
- IR: on load_ir, IR <= mem_rdata at the clock edge.
- PC update priority:
  - load_pc: PC <= IR operand.
  - else inc_pc: PC <= PC+1, modulo 2^AWIDTH (31 wraps to 0).
  - load_pc and inc_pc together: load wins.
- AC update on load_ac, using the opcode currently held in IR:
  - ADD: AC <= AC+mem_rdata, truncated to DWIDTH, carry discarded.
  - AND: AC <= AC & mem_rdata.
  - XOR: AC <= AC ^ mem_rdata.
  - LDA: AC <= mem_rdata.
  - HLT, SKZ, STO, JMP: AC holds.
- Simultaneous load_ir and load_ac: both take effect; the ALU uses the pre-update IR opcode.
- zero = (AC == 0), combinational from registered AC; no latency beyond the AC register.
- opcode = IR[DWIDTH-1:DWIDTH-3], cast to opcode_t, combinational.
- Halt:
  - halt high at a clock edge sets halted=1 (sticky until reset).
  - Once halted=1: PC, IR, AC and phase freeze, and mem_re and mem_we are forced to 0.
  - Strobes arriving in the same cycle that halt is first sampled still take effect.
- Reset mid-instruction: all state returns to reset values immediately; the next instruction fetch starts at phase 0 from address 0.

Optional Feature:
- Macro DATAPATH_PROTO_CHECK_EN.
- When defined, proto_err is set (sticky until reset) when any of the following occurs while halted=0:
  - load_ir outside phases 2-3;
  - mem_wr outside phases 6-7;
  - load_ac outside phase 7;
  - mem_wr and mem_rd in the same cycle.
- When not defined, proto_err is tied to 0 and no checker logic is synthesized.

Decomposition:
- Package typedefs holds:
  - opcode_t: 3-bit enum HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP;
  - phase_t: 3-bit enum INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, shared with the controller;
  - default width constants.
- One natural sub-module, risc_alu: combinational ALU taking opcode, AC and mem_rdata and producing the result.

Test Plan:
- Reset then phase check: release rst_; mem_addr=0 in phases 0-3; opcode=HLT and zero=1.
- Instruction load with opcode=LDA, operand 5 (mem_rdata 8'b101_00101) and load_ir in phase 2: in phase 4, opcode=LDA and mem_addr=5. Then mem_rdata=8'h00 with load_ac in phase 7: AC=0, zero=1.
- ADD with AC=8'hF0, mem_rdata=8'h20 and load_ac: AC=8'h10 (carry dropped), zero=0. Then XOR with 8'h10: AC=0, zero=1.
- PC priority with PC=31:
  - inc_pc alone: PC=0 (wrap);
  - IR operand=9, load_pc and inc_pc asserted together: PC=9.
- Halt with halt high plus inc_pc and mem_wr in the same cycle:
  - halted=1 and PC incremented once;
  - on later cycles PC, AC and phase hold, and mem_we=0 even with mem_wr=1;
  - rst_ low clears halted.
- Protocol check (DATAPATH_PROTO_CHECK_EN): load_ir in phase 5 gives proto_err=1, which persists until reset. Without the macro, proto_err stays 0.
